// File: rtl/midi_tx.sv
// MIDI note-on/note-off transmitter: 8N1 serial framing of status/key/velocity
// bytes, with optional running-status suppression of a repeated status byte.
module midi_tx #(
  parameter int unsigned CLK_PER_BIT    = 2080,
  parameter bit          RUNNING_STATUS = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_note_on,
  input  logic [3:0] ev_channel,
  input  logic [6:0] ev_key,
  input  logic [6:0] ev_velocity,
  output logic       serial,
  output logic       busy,
  output logic       msg_done
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  // msg_done is registered, so it is raised one count early; needs CLK_PER_BIT >= 2.
  localparam logic [CW-1:0] CNT_DONE = CW'(CLK_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [1:0]    left_q;
  logic [7:0]    shift_q;
  logic [15:0]   pend_q;
  logic [7:0]    msg_status_q;
  logic [7:0]    last_status_q;
  logic          last_valid_q;
  logic          serial_q, busy_q, done_q, ready_q;

  logic [7:0]    status_d;
  logic          omit_d;

  always_comb begin
    status_d = {1'b1, 2'b00, ev_note_on, ev_channel};
    omit_d   = RUNNING_STATUS && last_valid_q && (last_status_q == status_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      left_q        <= '0;
      shift_q       <= '0;
      pend_q        <= '0;
      msg_status_q  <= '0;
      last_status_q <= '0;
      last_valid_q  <= 1'b0;
      serial_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          serial_q <= 1'b1;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          ready_q  <= 1'b1;
          if (ev_valid && ready_q) begin
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            serial_q     <= 1'b0;
            state_q      <= START;
            cnt_q        <= '0;
            msg_status_q <= status_d;
            // pend_q holds the bytes still to follow, next one in the low byte.
            if (omit_d) begin
              shift_q <= {1'b0, ev_key};
              pend_q  <= {8'h00, 1'b0, ev_velocity};
              left_q  <= 2'd1;
            end else begin
              shift_q <= status_d;
              pend_q  <= {1'b0, ev_velocity, 1'b0, ev_key};
              left_q  <= 2'd2;
            end
          end
        end
        START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            bit_q    <= '0;
            state_q  <= DATA;
            serial_q <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q  <= STOP;
              serial_q <= 1'b1;
            end else begin
              bit_q    <= bit_q + 3'd1;
              serial_q <= shift_q[0];
              shift_q  <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (left_q != 2'd0) begin
              state_q  <= START;
              serial_q <= 1'b0;
              shift_q  <= pend_q[7:0];
              pend_q   <= pend_q >> 8;
              left_q   <= left_q - 2'd1;
            end else begin
              state_q       <= IDLE;
              done_q        <= 1'b0;
              busy_q        <= 1'b0;
              ready_q       <= 1'b1;
              last_status_q <= msg_status_q;
              last_valid_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CNT_DONE && left_q == 2'd0) done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign serial   = serial_q;
  assign busy     = busy_q;
  assign msg_done = done_q;
  assign ev_ready = ready_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx: one running-status instance and one always-status instance,
// each compared cycle by cycle against a waveform built from the expected byte list.
module tb_midi_tx;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] vld;
  logic       on;
  logic [3:0] ch;
  logic [6:0] key, vel;
  logic [1:0] rdy, ser, bsy, done;

  midi_tx #(.CLK_PER_BIT(N), .RUNNING_STATUS(1'b1)) dut0 (
    .clock(clk), .reset(rst), .ev_valid(vld[0]), .ev_ready(rdy[0]),
    .ev_note_on(on), .ev_channel(ch), .ev_key(key), .ev_velocity(vel),
    .serial(ser[0]), .busy(bsy[0]), .msg_done(done[0])
  );

  midi_tx #(.CLK_PER_BIT(N), .RUNNING_STATUS(1'b0)) dut1 (
    .clock(clk), .reset(rst), .ev_valid(vld[1]), .ev_ready(rdy[1]),
    .ev_note_on(on), .ev_channel(ch), .ev_key(key), .ev_velocity(vel),
    .serial(ser[1]), .busy(bsy[1]), .msg_done(done[1])
  );

  int checks = 0;
  int errors = 0;
  bit         ls_valid [2];
  logic [7:0] ls [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send one event to instance d and check every cycle of the resulting message.
  task automatic run_msg(input int d, input bit n_on, input logic [3:0] c,
                         input logic [6:0] k, input logic [6:0] v,
                         input bit hold, input int abort_at);
    logic [7:0] st;
    logic [7:0] q[$];
    logic [7:0] by;
    bit         omit;
    int         len, w, pos, b, i;
    logic       exp_bit;
    st   = (n_on ? 8'h90 : 8'h80) + {4'h0, c};
    omit = (d == 0) && ls_valid[d] && (ls[d] == st);
    q    = {};
    if (!omit) q.push_back(st);
    q.push_back({1'b0, k});
    q.push_back({1'b0, v});
    len = q.size() * 10 * N;

    vld = '0;
    w = 0;
    while (rdy[d] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'd0, rdy[d]}, 32'd1);
    on = n_on; ch = c; key = k; vel = v;
    vld[d] = 1'b1;

    for (int t = 1; t <= len; t++) begin
      @(negedge clk);
      if (hold) begin
        on = 1'($urandom); ch = 4'($urandom); key = 7'($urandom); vel = 7'($urandom);
      end else begin
        vld[d] = 1'b0;
      end
      pos = (t - 1) / N;
      b   = pos / 10;
      i   = pos % 10;
      by  = q[b];
      if (i == 0) exp_bit = 1'b0;
      else if (i == 9) exp_bit = 1'b1;
      else exp_bit = by[i-1];
      chk("serial", {31'd0, ser[d]}, {31'd0, exp_bit});
      chk("busy", {31'd0, bsy[d]}, 32'd1);
      chk("msg_done", {31'd0, done[d]}, (t == len) ? 32'd1 : 32'd0);
      chk("ready_busy", {31'd0, rdy[d]}, 32'd0);
      if (t == abort_at) begin
        rst = 1'b0;
        vld = '0;
        @(negedge clk);
        chk("abort_serial", {31'd0, ser[d]}, 32'd1);
        chk("abort_busy", {31'd0, bsy[d]}, 32'd0);
        chk("abort_done", {31'd0, done[d]}, 32'd0);
        chk("abort_ready", {31'd0, rdy[d]}, 32'd0);
        rst = 1'b1;
        ls_valid[0] = 1'b0;
        ls_valid[1] = 1'b0;
        @(negedge clk);
        chk("abort_ready_rise", {31'd0, rdy[d]}, 32'd1);
        return;
      end
    end
    ls[d] = st;
    ls_valid[d] = 1'b1;
    @(negedge clk);
    chk("idle_serial", {31'd0, ser[d]}, 32'd1);
    chk("idle_busy", {31'd0, bsy[d]}, 32'd0);
    chk("idle_done", {31'd0, done[d]}, 32'd0);
    chk("idle_ready", {31'd0, rdy[d]}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; vld = '0; on = 1'b0; ch = '0; key = '0; vel = '0;
    ls_valid[0] = 1'b0; ls_valid[1] = 1'b0;
    ls[0] = '0; ls[1] = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_serial", {31'd0, ser[d]}, 32'd1);
      chk("rst_busy", {31'd0, bsy[d]}, 32'd0);
      chk("rst_done", {31'd0, done[d]}, 32'd0);
      chk("rst_ready", {31'd0, rdy[d]}, 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ready_rise0", {31'd0, rdy[0]}, 32'd1);
    chk("ready_rise1", {31'd0, rdy[1]}, 32'd1);

    run_msg(0, 1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 0);
    run_msg(0, 1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 0);
    run_msg(0, 1'b0, 4'd3, 7'd60, 7'd0,   1'b0, 0);
    run_msg(0, 1'b1, 4'd5, 7'd10, 7'd20,  1'b1, 0);
    run_msg(0, 1'b1, 4'd5, 7'd11, 7'd21,  1'b0, 0);
    run_msg(0, 1'b1, 4'd2, 7'd60, 7'd100, 1'b0, 50);
    run_msg(0, 1'b1, 4'd2, 7'd60, 7'd100, 1'b0, 0);
    run_msg(1, 1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 0);
    run_msg(1, 1'b1, 4'd0, 7'd60, 7'd100, 1'b0, 0);

    for (int r = 0; r < 12; r++) begin
      run_msg(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 1)), 7'($urandom), 7'($urandom),
              1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
